dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RV32I core: the far end of the dmem request/response interface that the MEM stage drives and the WB stage consumes. It accepts one request (word address, read mask, write mask, write data), performs a byte-masked access to an internal word array after a programmable latency, and returns a single-cycle `dmem_resp` with the full aligned 32-bit word on `dmem_rdata`. Sub-word extraction and sign extension are performed by the WB stage, not here. Used as the bench/FPGA data memory and as the latency-injection model for stall-logic verification.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 2..65536.
- `LATENCY`, 2: cycles from request acceptance to `dmem_resp`; 1..15.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `dmem_addr` input 32: byte address; bits [1:0] ignored, bits [log2(DEPTH)+1:2] index the array, higher bits ignored (address wraps modulo DEPTH words).
- `dmem_rmask` input 4: byte read mask; nonzero requests a read.
- `dmem_wmask` input 4: byte write mask; bit i enables lane [8i+7:8i].
- `dmem_wdata` input 32: write data, already lane-aligned by the initiator.
- `dmem_rdata` output 32: word read; valid when `dmem_resp`=1, holds its last value otherwise.
- `dmem_resp` output 1: one-cycle response pulse, one per accepted request.
- `dmem_err` output 1: sticky protocol-violation flag.

## Operation
- Request present in a cycle when `dmem_rmask`≠0 or `dmem_wmask`≠0.
- States: IDLE, BUSY. `accept_ok` = IDLE, or BUSY with counter = 0 (response completing this cycle).
- Accept: request present and `accept_ok` → latch addr/masks/wdata, load counter with LATENCY−1, state BUSY.
- BUSY, counter>0: decrement. Counter=0: at this edge perform the access, register `dmem_resp`=1 and `dmem_rdata`; go IDLE unless a new request is accepted at the same edge (then reload counter, stay BUSY).
- Access: `dmem_rdata` = array word before this request's write; then write lanes selected by `dmem_wmask`. Read and write masks both nonzero is legal: a read-modify-write returning the pre-write word.
- Write-only request still pulses `dmem_resp`; `dmem_rdata` updates to the pre-write word.
- Request present while not `accept_ok` → dropped (no access, no response), `dmem_err` set to 1 until reset.
- Array contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state IDLE, counter 0, `dmem_resp`=0, `dmem_rdata`=0, `dmem_err`=0, latched request cleared.
- Reset asserted mid-request: the in-flight request is abandoned, no response, no write (writes take effect only at the completing edge).
- Request accepted in cycle T → `dmem_resp`=1 exactly in cycle T+LATENCY, for one cycle.
- LATENCY=1: response in cycle T+1; with `accept_ok` in BUSY-counter-0, one request per cycle sustained.
- Back-to-back: a request presented in the cycle before the response pulse (cycle T+LATENCY−1) is accepted; its response lands in T+2·LATENCY−1. Throughput = one request per LATENCY cycles.
- Ordering: each access observes every write from requests accepted earlier.
- Inputs are sampled only at the acceptance edge; they may change freely afterwards.

## Test plan
- Reset then idle 10 cycles, no requests → `dmem_resp`=0, `dmem_rdata`=0, `dmem_err`=0 throughout.
- LATENCY=2: write addr 0x10, wmask 4'b1111, wdata 0xDEADBEEF in cycle 5 → `dmem_resp` pulse in cycle 7 only; read addr 0x10 accepted cycle 8 → cycle 10 `dmem_resp`=1, `dmem_rdata`=0xDEADBEEF.
- Partial write: word 0x20 holds 0x11223344, write wmask 4'b0100 wdata 0x00AA0000 → subsequent read returns 0x11AA3344; combined rmask 4'b1111/wmask 4'b0001 wdata 0x000000FF → returns 0x11AA3344, later read 0x11AA33FF.
- Wrap: DEPTH=256, write 0x12345678 to byte addr 0x400, read byte addr 0x0 → 0x12345678; read addr 0x403 → same word.
- Violation: LATENCY=3, accept read cycle 2, present write in cycle 3 → write dropped (array unchanged), single response in cycle 5, `dmem_err`=1 from cycle 4 until `rst_n` low.
- Reset mid-flight: write accepted cycle 2, `rst_n`=0 in cycle 3 → no `dmem_resp`, outputs zero immediately, later read of that address returns the old contents.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the pipelined RV32I core. Accepts
//               one word request at a time (byte address, read mask, write
//               mask, write data) and performs a byte-masked access to an
//               internal word array LATENCY cycles after acceptance. It
//               returns a one-cycle dmem_resp pulse together with the
//               pre-write aligned word on dmem_rdata.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               dmem_addr  [31:0]    - byte address (word index in [AW+1:2])
//               dmem_rmask [3:0]     - read byte mask (nonzero = read)
//               dmem_wmask [3:0]     - write byte mask, one bit per lane
//               dmem_wdata [31:0]    - lane-aligned write data
//               dmem_rdata [31:0]    - word returned with dmem_resp
//               dmem_resp            - one-cycle response pulse
//               dmem_err             - sticky dropped-request flag
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    localparam int        AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            resp_q,  resp_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q,   err_d;

    // Word array; deliberately not reset.
    logic [31:0]     mem_q [DEPTH];

    logic            req;
    logic            complete;
    logic            accept_ok;
    logic            accept;

    // Only the word-index bits of the address matter; the byte offset and
    // the bits above the array size are dropped so the address wraps.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr[31:AW+2], dmem_addr[1:0]};

    assign req       = (|dmem_rmask) | (|dmem_wmask);
    // The completing cycle frees the slot, so a new request may be taken
    // at the same edge the current one is serviced.
    assign complete  = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign accept_ok = (state_q == ST_IDLE) || complete;
    assign accept    = req && accept_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        resp_d  = complete;
        rdata_d = rdata_q;
        err_d   = err_q | (req & ~accept_ok);

        // Read returns the word as it was before this request's own write.
        if (complete) begin
            rdata_d = mem_q[addr_q];
        end

        if (accept) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
            addr_d  = dmem_addr[AW+1:2];
            wmask_d = dmem_wmask;
            wdata_d = dmem_wdata;
        end else if (complete) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_BUSY) begin
            cnt_d   = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wmask_q <= 4'd0;
            wdata_q <= 32'd0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Writes land only at the completing edge; a reset before then leaves
    // the array untouched because it forces the state back to idle.
    always_ff @(posedge clk) begin
        if (complete) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign dmem_rdata = rdata_q;
    assign dmem_resp  = resp_q;
    assign dmem_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (DEPTH=256, LATENCY=2).
//               The driver pushes the expected word and response edge for
//               every request it expects to be accepted; a monitor pops and
//               compares on each dmem_resp pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .dmem_err   (dmem_err)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable when read at negedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dmem_resp) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: resp=1 at edge %0d, required no response", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (cyc != e.cyc) begin
                        failures++;
                        $display("FAIL resp_timing: resp at edge %0d, required edge %0d", cyc, e.cyc);
                    end
                    if (e.chk && dmem_rdata !== e.data) begin
                        failures++;
                        $display("FAIL resp_rdata: rdata=%08h, required %08h (edge %0d)",
                                 dmem_rdata, e.data, cyc);
                    end
                end
            end
        end
    end

    // Present one request for one edge (called at a negedge). When accepted,
    // the response is expected LATENCY edges after the accepting edge.
    task automatic issue(input logic [31:0] addr, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd,
                         input bit accepted, input bit chk,
                         input logic [31:0] exp_data);
        exp_t e;
        dmem_addr  = addr;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        if (accepted) begin
            e.data = exp_data;
            e.chk  = chk;
            e.cyc  = cyc + 1 + LATENCY;
            sb_q.push_back(e);
        end
        @(negedge clk);
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [31:0] rd,
                              input logic rs, input logic er);
        checks++;
        if (dmem_rdata !== rd || dmem_resp !== rs || dmem_err !== er) begin
            failures++;
            $display("FAIL %s: rdata=%08h resp=%b err=%b, required rdata=%08h resp=%b err=%b",
                     name, dmem_rdata, dmem_resp, dmem_err, rd, rs, er);
        end
    endtask

    task automatic check_err(input string name, input logic er);
        checks++;
        if (dmem_err !== er) begin
            failures++;
            $display("FAIL %s: err=%b, required %b", name, dmem_err, er);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_addr  = 32'd0;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        dmem_wdata = 32'd0;

        idle(3);
        check_outs("reset_state", 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle with no requests: outputs stay at reset values.
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check_outs("idle_quiet", 32'd0, 1'b0, 1'b0);
        end

        // Full write then read back; requests spaced at maximum throughput.
        issue(32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0);
        idle(1);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1, 1, 32'hDEADBEEF);
        idle(1);

        // Partial-lane write and read-modify-write returning pre-write word.
        issue(32'h20, 4'h0, 4'hF, 32'h11223344, 1, 0, 32'h0);
        idle(1);
        issue(32'h20, 4'h0, 4'b0100, 32'h00AA0000, 1, 1, 32'h11223344);
        idle(1);
        issue(32'h20, 4'hF, 4'h0, 32'h0, 1, 1, 32'h11AA3344);
        idle(1);
        issue(32'h20, 4'hF, 4'b0001, 32'h000000FF, 1, 1, 32'h11AA3344);
        idle(1);
        issue(32'h20, 4'h1, 4'h0, 32'h0, 1, 1, 32'h11AA33FF);
        idle(1);

        // Address wrap modulo DEPTH words; byte offset ignored.
        issue(32'h400, 4'h0, 4'hF, 32'h12345678, 1, 0, 32'h0);
        idle(1);
        issue(32'h0, 4'hF, 4'h0, 32'h0, 1, 1, 32'h12345678);
        idle(1);
        issue(32'h403, 4'h2, 4'h0, 32'h0, 1, 1, 32'h12345678);
        idle(3);

        // Protocol violation: write presented while busy is dropped.
        check_err("err_before_violation", 1'b0);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1, 1, 32'hDEADBEEF);
        issue(32'h10, 4'h0, 4'hF, 32'h0BADF00D, 0, 0, 32'h0);
        check_err("err_set", 1'b1);
        idle(2);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1, 1, 32'hDEADBEEF);
        idle(3);
        check_err("err_sticky", 1'b1);

        // Reset mid-flight: in-flight write abandoned, outputs clear at once.
        issue(32'h10, 4'h0, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_outs("reset_midflight", 32'd0, 1'b0, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        check_outs("after_reset_quiet", 32'd0, 1'b0, 1'b0);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1, 1, 32'hDEADBEEF);
        idle(5);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL resp_missing: %0d responses outstanding, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
